control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired Moore control sequencer for the Mini SRC datapath; replaces bench-driven control with IR-decoded generation of every datapath enable and select strobe.
- Sits beside `datapath`. Consumes IR and CON from it and drives the same control bundle (HIin…BAout, Read, write, IncPC) that the benches drive today.
- Runs a fixed fetch (T0–T2), then an opcode-specific execute sequence (T3–T7), then returns to T0.

Parameters:
- RESET_PC_HOLD, 1, number of idle cycles after Reset deasserts before the first T0 (range 1–3).

Ports:
- Clock  in  1  system clock, rising-edge.
- Reset  in  1  synchronous, active-high reset.
- IR  in  32  instruction register contents; opcode is IR[31:27].
- CON  in  1  branch-condition flag from CON FF logic.
- Stop  in  1  halt request; sampled at end of each instruction.
- HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin  out  1 each  register load enables.
- HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout  out  1 each  bus drive selects.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select/control.
- R15sel  out  1  forces register select to R15 (jal link).
- Read, write, IncPC  out  1 each  memory read, memory write pulse, PC increment.
- ALUop  out  5  ALU operation code.
- Run  out  1  1 while executing, 0 in HALT.

Behaviour:
- Clocking and reset:
  - One state per Clock cycle; all outputs are decoded solely from the state register and latched decode.
  - Synchronous active-high Reset: at the next rising Clock with Reset=1, state←RST, all strobes 0, ALUop=0, Run=0.
  - After Reset falls: RESET_PC_HOLD idle cycles, then T0 with Run=1.
  - Reset mid-instruction aborts immediately; no partial write pulse.
- Fetch:
  - T0: PCout, MARin.
  - T1: Read, MDRin, PCin, IncPC.
  - T2: MDRout, IRin.
- Decode:
  - Opcode latched at end of T2 from IR[31:27] into an internal op register; IR changes after T2 are ignored.
  - Opcode map: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010, jr 10011, jal 10100, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010.
  - Codes 11011–11111 execute as nop.
- Execute sequences (state after the last step is T0):
  - ld: T3 Grb BAout Yin; T4 Cout Zin; T5 ZLOout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - ldi: T3 Grb BAout Yin; T4 Cout Zin; T5 ZLOout Gra Rin.
  - st: T3 Grb BAout Yin; T4 Cout Zin; T5 ZLOout MARin; T6 Gra Rout MDRin; T7 write (exactly one cycle).
  - 3-reg ALU (add…or): T3 Grb Rout Yin; T4 Grc Rout Zin; T5 ZLOout Gra Rin.
  - immediate (addi, andi, ori): T3 Grb Rout Yin; T4 Cout Zin; T5 ZLOout Gra Rin.
  - mul/div: T3 Gra Rout Yin; T4 Grb Rout Zin; T5 ZLOout LOin; T6 ZHIout HIin.
  - neg/not: T3 Grb Rout Zin; T4 ZLOout Gra Rin.
  - br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin; T6 ZLOout, with PCin = CON sampled in T6. T6 is always visited; only PCin is conditional.
  - jr: T3 Gra Rout PCin.
  - jal: T3 PCout R15sel Rin; T4 Gra Rout PCin.
  - in: T3 INPORTout Gra Rin.
  - out: T3 Gra Rout OUTPORTin.
  - mfhi: T3 HIout Gra Rin.
  - mflo: T3 LOout Gra Rin.
  - nop: straight to T0.
  - halt: enter HALT (all strobes 0, Run=0); HALT is left only by Reset.
- ALUop:
  - 00011 (ADD) in every address/branch Zin step (ld, ldi, st, br).
  - Latched opcode in ALU/immediate/mul/div/neg/not Zin steps.
  - 0 elsewhere.
- Stop:
  - If Stop=1 on the last execute cycle of any instruction, next state is HALT instead of T0.
  - Stop during fetch or mid-execute is deferred until that instruction completes.
- Strobe exclusivity:
  - At most one bus-drive select (…out, Cout, BAout-with-Rout) is active in any state.
  - write and Read are never active together.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined:
  - Adds input Mem_ready (1 bit).
  - T1 and ld-T6 hold, with Read and MDRin asserted, until a cycle with Mem_ready=1. PCin/IncPC in T1 assert only on that final cycle.
  - st-T7 holds write until Mem_ready=1.
- Undefined: Mem_ready is absent; every state lasts exactly one cycle.

Test Plan:
- Reset held 2 cycles, RESET_PC_HOLD=1 -> all outputs 0 and Run=0 during reset; first T0 (PCout=MARin=1) exactly 2 cycles after Reset falls.
- brnz R6,25 (IR=0x93080019), CON=0 -> T3 CONin, T6 ZLOout=1 with PCin=0; next T0 after 7 cycles. Same IR with CON=1 -> PCin=1 in T6.
- add R3,R1,R2 (IR=0x19890000) -> T3 Grb Rout Yin, T4 Grc Rout Zin with ALUop=00011, T5 ZLOout Gra Rin; 6 cycles total.
- st (IR opcode 00010) -> write high in exactly one cycle (T7) and never overlapping Read; 8 cycles total.
- mul (opcode 01110) with Stop=1 asserted in T4 -> LOin in T5, HIin in T6, then HALT with Run=0; Reset required to resume.
- Reset asserted during ld T6 -> next cycle all strobes 0; no MDRout/Rin pulse occurs. With MEM_WAIT_EN and Mem_ready low 3 cycles, T1 lasts 4 cycles and IncPC pulses once.

Source files
------------

// File: rtl/control_unit.sv
`default_nettype none
// =============================================================================
// Module   : control_unit
// Brief    : Hardwired Moore control sequencer for the Mini SRC datapath.
//            Fetch T0-T2, opcode-specific execute T3-T7, HALT on halt/Stop.
//            Optional macro MEM_WAIT_EN adds the Mem_ready wait handshake.
// Revision : 1.0  initial release
// =============================================================================
module control_unit #(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic        Clock,
    input  logic        Reset,
`ifdef MEM_WAIT_EN
    input  logic        Mem_ready,
`endif
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        HIin,
    output logic        LOin,
    output logic        PCin,
    output logic        MDRin,
    output logic        Zin,
    output logic        Yin,
    output logic        MARin,
    output logic        IRin,
    output logic        CONin,
    output logic        OUTPORTin,
    output logic        HIout,
    output logic        LOout,
    output logic        ZHIout,
    output logic        ZLOout,
    output logic        PCout,
    output logic        MDRout,
    output logic        INPORTout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        R15sel,
    output logic        Read,
    output logic        write,
    output logic        IncPC,
    output logic [4:0]  ALUop,
    output logic        Run
);

    localparam logic [4:0] c_OP_LD   = 5'b00000;
    localparam logic [4:0] c_OP_LDI  = 5'b00001;
    localparam logic [4:0] c_OP_ST   = 5'b00010;
    localparam logic [4:0] c_OP_ADD  = 5'b00011;
    localparam logic [4:0] c_OP_ADDI = 5'b01011;
    localparam logic [4:0] c_OP_ANDI = 5'b01100;
    localparam logic [4:0] c_OP_ORI  = 5'b01101;
    localparam logic [4:0] c_OP_MUL  = 5'b01110;
    localparam logic [4:0] c_OP_DIV  = 5'b01111;
    localparam logic [4:0] c_OP_NEG  = 5'b10000;
    localparam logic [4:0] c_OP_NOT  = 5'b10001;
    localparam logic [4:0] c_OP_BR   = 5'b10010;
    localparam logic [4:0] c_OP_JR   = 5'b10011;
    localparam logic [4:0] c_OP_JAL  = 5'b10100;
    localparam logic [4:0] c_OP_IN   = 5'b10101;
    localparam logic [4:0] c_OP_OUT  = 5'b10110;
    localparam logic [4:0] c_OP_MFHI = 5'b10111;
    localparam logic [4:0] c_OP_MFLO = 5'b11000;
    localparam logic [4:0] c_OP_HALT = 5'b11010;

    localparam logic [1:0] c_HOLD_LAST = 2'(RESET_PC_HOLD - 1);

    typedef enum logic [3:0] {
        S_RST, S_HOLD, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef struct packed {
        logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
        logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout;
        logic Gra, Grb, Grc, Rin, Rout, BAout, R15sel;
        logic Read, write, IncPC;
        logic [4:0] ALUop;
        logic Run;
    } ctrl_t;

    state_t     r_state, w_state_n;
    logic [4:0] r_op, w_op_n;
    logic       r_stop_pend, w_stop_n;
    logic [1:0] r_hold_cnt, w_hold_n;
    ctrl_t      r_ctrl, w_ctrl;
    logic [2:0] w_step;
    logic       w_wait;
    logic       w_unused_ir;

    assign w_unused_ir = ^IR[26:0];

    // Index of the final execute step for each opcode (T2 means no execute phase).
    function automatic logic [2:0] f_last_step(input logic [4:0] op);
        case (op) inside
            c_OP_LD, c_OP_ST:                        f_last_step = 3'd7;
            c_OP_LDI, [5'd3:5'd13]:                  f_last_step = 3'd5;
            c_OP_MUL, c_OP_DIV, c_OP_BR:             f_last_step = 3'd6;
            c_OP_NEG, c_OP_NOT, c_OP_JAL:            f_last_step = 3'd4;
            c_OP_JR, c_OP_IN, c_OP_OUT,
            c_OP_MFHI, c_OP_MFLO:                    f_last_step = 3'd3;
            default:                                 f_last_step = 3'd2;
        endcase
    endfunction

    function automatic state_t f_step_state(input logic [2:0] step);
        case (step)
            3'd0:    f_step_state = S_T0;
            3'd1:    f_step_state = S_T1;
            3'd2:    f_step_state = S_T2;
            3'd3:    f_step_state = S_T3;
            3'd4:    f_step_state = S_T4;
            3'd5:    f_step_state = S_T5;
            3'd6:    f_step_state = S_T6;
            default: f_step_state = S_T7;
        endcase
    endfunction

    always_comb begin
        case (r_state)
            S_T1:    w_step = 3'd1;
            S_T2:    w_step = 3'd2;
            S_T3:    w_step = 3'd3;
            S_T4:    w_step = 3'd4;
            S_T5:    w_step = 3'd5;
            S_T6:    w_step = 3'd6;
            S_T7:    w_step = 3'd7;
            default: w_step = 3'd0;
        endcase
    end

`ifdef MEM_WAIT_EN
    assign w_wait = !Mem_ready && ((r_state == S_T1) ||
                                   (r_state == S_T6 && r_op == c_OP_LD) ||
                                   (r_state == S_T7 && r_op == c_OP_ST));
`else
    assign w_wait = 1'b0;
`endif

    // Next-state logic; the opcode is taken straight from IR while leaving T2.
    always_comb begin
        w_op_n    = (r_state == S_T2) ? IR[31:27] : r_op;
        w_state_n = r_state;
        w_stop_n  = r_stop_pend;
        w_hold_n  = r_hold_cnt;
        case (r_state)
            S_RST: begin
                w_state_n = S_HOLD;
                w_hold_n  = 2'd0;
            end
            S_HOLD: begin
                if (r_hold_cnt == c_HOLD_LAST) w_state_n = S_T0;
                else                           w_hold_n  = r_hold_cnt + 2'd1;
            end
            S_HALT: w_state_n = S_HALT;
            default: begin
                w_stop_n = r_stop_pend | Stop;
                if (w_wait) begin
                    w_state_n = r_state;
                end else if (w_step == f_last_step(w_op_n)) begin
                    w_stop_n  = 1'b0;
                    w_state_n = (w_op_n == c_OP_HALT || r_stop_pend || Stop) ? S_HALT : S_T0;
                end else begin
                    w_state_n = f_step_state(w_step + 3'd1);
                end
            end
        endcase
    end

    // Strobe decode for the state being entered, so outputs come straight from flops.
    always_comb begin
        w_ctrl = '0;
        case (w_state_n)
            S_T0: begin w_ctrl.PCout = 1'b1; w_ctrl.MARin = 1'b1; end
            S_T1: begin
                w_ctrl.Read  = 1'b1;
                w_ctrl.MDRin = 1'b1;
`ifndef MEM_WAIT_EN
                w_ctrl.PCin  = 1'b1;
                w_ctrl.IncPC = 1'b1;
`endif
            end
            S_T2: begin w_ctrl.MDRout = 1'b1; w_ctrl.IRin = 1'b1; end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                case (w_op_n) inside
                    c_OP_LD, c_OP_LDI, c_OP_ST: begin
                        case (w_state_n)
                            S_T3: begin w_ctrl.Grb = 1'b1; w_ctrl.BAout = 1'b1; w_ctrl.Yin = 1'b1; end
                            S_T4: begin w_ctrl.Cout = 1'b1; w_ctrl.Zin = 1'b1; w_ctrl.ALUop = c_OP_ADD; end
                            S_T5: begin
                                w_ctrl.ZLOout = 1'b1;
                                if (w_op_n == c_OP_LDI) begin w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
                                else                          w_ctrl.MARin = 1'b1;
                            end
                            S_T6: begin
                                w_ctrl.MDRin = 1'b1;
                                if (w_op_n == c_OP_LD) w_ctrl.Read = 1'b1;
                                else begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; end
                            end
                            S_T7: begin
                                if (w_op_n == c_OP_LD) begin
                                    w_ctrl.MDRout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                                end else begin
                                    w_ctrl.write = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    [5'd3:5'd10], c_OP_ADDI, c_OP_ANDI, c_OP_ORI: begin
                        case (w_state_n)
                            S_T3: begin w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Yin = 1'b1; end
                            S_T4: begin
                                w_ctrl.Zin   = 1'b1;
                                w_ctrl.ALUop = w_op_n;
                                if (w_op_n inside {c_OP_ADDI, c_OP_ANDI, c_OP_ORI}) w_ctrl.Cout = 1'b1;
                                else begin w_ctrl.Grc = 1'b1; w_ctrl.Rout = 1'b1; end
                            end
                            S_T5: begin w_ctrl.ZLOout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    c_OP_MUL, c_OP_DIV: begin
                        case (w_state_n)
                            S_T3: begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Yin = 1'b1; end
                            S_T4: begin
                                w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Zin = 1'b1;
                                w_ctrl.ALUop = w_op_n;
                            end
                            S_T5: begin w_ctrl.ZLOout = 1'b1; w_ctrl.LOin = 1'b1; end
                            S_T6: begin w_ctrl.ZHIout = 1'b1; w_ctrl.HIin = 1'b1; end
                            default: ;
                        endcase
                    end
                    c_OP_NEG, c_OP_NOT: begin
                        case (w_state_n)
                            S_T3: begin
                                w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Zin = 1'b1;
                                w_ctrl.ALUop = w_op_n;
                            end
                            S_T4: begin w_ctrl.ZLOout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    c_OP_BR: begin
                        case (w_state_n)
                            S_T3: begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.CONin = 1'b1; end
                            S_T4: begin w_ctrl.PCout = 1'b1; w_ctrl.Yin = 1'b1; end
                            S_T5: begin w_ctrl.Cout = 1'b1; w_ctrl.Zin = 1'b1; w_ctrl.ALUop = c_OP_ADD; end
                            S_T6: begin w_ctrl.ZLOout = 1'b1; w_ctrl.PCin = CON; end
                            default: ;
                        endcase
                    end
                    c_OP_JR: begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.PCin = 1'b1; end
                    c_OP_JAL: begin
                        if (w_state_n == S_T3) begin
                            w_ctrl.PCout = 1'b1; w_ctrl.R15sel = 1'b1; w_ctrl.Rin = 1'b1;
                        end else begin
                            w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.PCin = 1'b1;
                        end
                    end
                    c_OP_IN:   begin w_ctrl.INPORTout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
                    c_OP_OUT:  begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.OUTPORTin = 1'b1; end
                    c_OP_MFHI: begin w_ctrl.HIout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
                    c_OP_MFLO: begin w_ctrl.LOout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        w_ctrl.Run = (w_state_n inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7});
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= S_RST;
            r_op        <= 5'd0;
            r_stop_pend <= 1'b0;
            r_hold_cnt  <= 2'd0;
            r_ctrl      <= '0;
        end else begin
            r_state     <= w_state_n;
            r_op        <= w_op_n;
            r_stop_pend <= w_stop_n;
            r_hold_cnt  <= w_hold_n;
            r_ctrl      <= w_ctrl;
        end
    end

`ifdef MEM_WAIT_EN
    logic w_t1_go;
    // PC update in T1 fires only on the cycle the memory read completes.
    assign w_t1_go = (r_state == S_T1) && Mem_ready;
    assign PCin    = r_ctrl.PCin  | w_t1_go;
    assign IncPC   = r_ctrl.IncPC | w_t1_go;
`else
    assign PCin    = r_ctrl.PCin;
    assign IncPC   = r_ctrl.IncPC;
`endif

    assign HIin      = r_ctrl.HIin;
    assign LOin      = r_ctrl.LOin;
    assign MDRin     = r_ctrl.MDRin;
    assign Zin       = r_ctrl.Zin;
    assign Yin       = r_ctrl.Yin;
    assign MARin     = r_ctrl.MARin;
    assign IRin      = r_ctrl.IRin;
    assign CONin     = r_ctrl.CONin;
    assign OUTPORTin = r_ctrl.OUTPORTin;
    assign HIout     = r_ctrl.HIout;
    assign LOout     = r_ctrl.LOout;
    assign ZHIout    = r_ctrl.ZHIout;
    assign ZLOout    = r_ctrl.ZLOout;
    assign PCout     = r_ctrl.PCout;
    assign MDRout    = r_ctrl.MDRout;
    assign INPORTout = r_ctrl.INPORTout;
    assign Cout      = r_ctrl.Cout;
    assign Gra       = r_ctrl.Gra;
    assign Grb       = r_ctrl.Grb;
    assign Grc       = r_ctrl.Grc;
    assign Rin       = r_ctrl.Rin;
    assign Rout      = r_ctrl.Rout;
    assign BAout     = r_ctrl.BAout;
    assign R15sel    = r_ctrl.R15sel;
    assign Read      = r_ctrl.Read;
    assign write     = r_ctrl.write;
    assign ALUop     = r_ctrl.ALUop;
    assign Run       = r_ctrl.Run;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// =============================================================================
// Module   : tb_control_unit
// Brief    : Self-checking bench for control_unit: directed vector table,
//            reset-abort sequence and randomized instruction stream.
// Revision : 1.0  initial release
// =============================================================================
module tb_control_unit;

    localparam int TB_HOLD = 1;

    logic        Clock = 1'b0;
    logic        Reset, CON, Stop;
    logic [31:0] IR;
    logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
    logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, R15sel, Read, write, IncPC, Run;
    logic [4:0]  ALUop;
    logic [27:0] obs;

    always #5 Clock = ~Clock;

    control_unit #(.RESET_PC_HOLD(TB_HOLD)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .CON(CON), .Stop(Stop),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin),
        .MARin(MARin), .IRin(IRin), .CONin(CONin), .OUTPORTin(OUTPORTin),
        .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
        .MDRout(MDRout), .INPORTout(INPORTout), .Cout(Cout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .R15sel(R15sel), .Read(Read), .write(write), .IncPC(IncPC),
        .ALUop(ALUop), .Run(Run)
    );

    assign obs = {IncPC, write, Read, R15sel, BAout, Rout, Rin, Grc, Grb, Gra,
                  Cout, INPORTout, MDRout, PCout, ZLOout, ZHIout, LOout, HIout,
                  OUTPORTin, CONin, IRin, MARin, Yin, Zin, MDRin, PCin, LOin, HIin};

    typedef struct packed {
        logic [27:0] mask;
        logic [4:0]  alu;
    } step_t;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        con;
        int          stop_at;
        int          cycles;
        int          halt;
    } vec_t;

    localparam logic [27:0] c_T0_MASK = (28'd1 << 14) | (28'd1 << 6);
    localparam string c_FETCH = "PCout MARin|Read MDRin PCin IncPC|MDRout IRin";

    int    n_tests = 0;
    int    n_fail  = 0;
    step_t exp_q[$];
    vec_t  tbl[13];

    function automatic int name_idx(input string t);
        case (t)
            "HIin": return 0;   "LOin": return 1;    "PCin": return 2;    "MDRin": return 3;
            "Zin": return 4;    "Yin": return 5;     "MARin": return 6;   "IRin": return 7;
            "CONin": return 8;  "OUTPORTin": return 9; "HIout": return 10; "LOout": return 11;
            "ZHIout": return 12; "ZLOout": return 13; "PCout": return 14; "MDRout": return 15;
            "INPORTout": return 16; "Cout": return 17; "Gra": return 18;  "Grb": return 19;
            "Grc": return 20;   "Rin": return 21;    "Rout": return 22;   "BAout": return 23;
            "R15sel": return 24; "Read": return 25;  "write": return 26;  "IncPC": return 27;
            default: return -1;
        endcase
    endfunction

    // Execute steps per opcode, written as the datapath RTN; "|" separates cycles.
    function automatic string exec_str(input logic [4:0] op);
        case (op) inside
            5'd0:          return "|Grb BAout Yin|Cout Zin ADD|ZLOout MARin|Read MDRin|MDRout Gra Rin";
            5'd1:          return "|Grb BAout Yin|Cout Zin ADD|ZLOout Gra Rin";
            5'd2:          return "|Grb BAout Yin|Cout Zin ADD|ZLOout MARin|Gra Rout MDRin|write";
            [5'd3:5'd10]:  return "|Grb Rout Yin|Grc Rout Zin OP|ZLOout Gra Rin";
            [5'd11:5'd13]: return "|Grb Rout Yin|Cout Zin OP|ZLOout Gra Rin";
            5'd14, 5'd15:  return "|Gra Rout Yin|Grb Rout Zin OP|ZLOout LOin|ZHIout HIin";
            5'd16, 5'd17:  return "|Grb Rout Zin OP|ZLOout Gra Rin";
            5'd18:         return "|Gra Rout CONin|PCout Yin|Cout Zin ADD|ZLOout PCin?";
            5'd19:         return "|Gra Rout PCin";
            5'd20:         return "|PCout R15sel Rin|Gra Rout PCin";
            5'd21:         return "|INPORTout Gra Rin";
            5'd22:         return "|Gra Rout OUTPORTin";
            5'd23:         return "|HIout Gra Rin";
            5'd24:         return "|LOout Gra Rin";
            default:       return "";
        endcase
    endfunction

    function automatic step_t apply_tok(input string t, input logic [4:0] op,
                                        input logic con, input step_t cur);
        step_t r;
        int    idx;
        r = cur;
        if (t == "ADD")        r.alu = 5'b00011;
        else if (t == "OP")    r.alu = op;
        else if (t == "PCin?") r.mask[2] = con;
        else begin
            idx = name_idx(t);
            if (idx >= 0) r.mask[idx] = 1'b1;
        end
        return r;
    endfunction

    function automatic void build_exp(input logic [4:0] op, input logic con);
        string s;
        int    st;
        step_t cur;
        byte   ch;
        exp_q.delete();
        s   = {c_FETCH, exec_str(op)};
        cur = '0;
        st  = 0;
        for (int i = 0; i <= s.len(); i++) begin
            ch = (i == s.len()) ? "|" : s.getc(i);
            if (ch == " " || ch == "|") begin
                if (i > st) cur = apply_tok(s.substr(st, i - 1), op, con, cur);
                st = i + 1;
                if (ch == "|") begin
                    exp_q.push_back(cur);
                    cur = '0;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [27:0] em,
                       input logic [4:0] ea, input logic er);
        n_tests++;
        if (obs !== em || ALUop !== ea || Run !== er) begin
            n_fail++;
            $display("FAIL %s: got strobes=%07h ALUop=%05b Run=%b, want strobes=%07h ALUop=%05b Run=%b",
                     name, obs, ALUop, Run, em, ea, er);
        end
    endtask

    task automatic do_reset(input int ncyc);
        Reset = 1'b1;
        Stop  = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge Clock);
            chk("reset", 28'd0, 5'd0, 1'b0);
        end
        Reset = 1'b0;
        for (int i = 0; i < TB_HOLD; i++) begin
            @(negedge Clock);
            chk("reset_hold", 28'd0, 5'd0, 1'b0);
        end
        @(negedge Clock);
    endtask

    // Called at a negedge with T0 visible; leaves the next state visible.
    task automatic run_instr(input string name, input logic [31:0] ir, input logic con,
                             input int stop_at, input int abort_at, input int n_cyc,
                             input int exp_halt, output bit halted);
        logic [4:0] op;
        int         len;
        bit         aborted;
        op      = ir[31:27];
        aborted = 1'b0;
        build_exp(op, con);
        len = (n_cyc < 0) ? exp_q.size() : n_cyc;
        IR  = ir;
        CON = con;
        for (int k = 0; k < len && !aborted; k++) begin
            if (k < exp_q.size())
                chk($sformatf("%s step%0d", name, k), exp_q[k].mask, exp_q[k].alu, 1'b1);
            else
                chk($sformatf("%s step%0d", name, k), c_T0_MASK, 5'd0, 1'b1);
            if (k == abort_at) begin
                Reset   = 1'b1;
                aborted = 1'b1;
            end else begin
                Stop = (k == stop_at);
                if (k == 3) IR = $urandom;
                @(negedge Clock);
            end
        end
        Stop = 1'b0;
        if (exp_halt >= 0) halted = (exp_halt != 0);
        else halted = (op == 5'b11010) || (stop_at >= 0 && stop_at < exp_q.size());
        if (aborted) begin
            halted = 1'b0;
        end else if (halted) begin
            chk({name, " end_halt"}, 28'd0, 5'd0, 1'b0);
        end else begin
            chk({name, " end_t0"}, c_T0_MASK, 5'd0, 1'b1);
        end
    endtask

    task automatic after_halt();
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            chk("halt_hold", 28'd0, 5'd0, 1'b0);
        end
        do_reset(2);
    endtask

    initial begin
        bit          h;
        logic [4:0]  rop;
        logic [31:0] rir;
        int          rstop;
        Reset = 1'b1;
        Stop  = 1'b0;
        CON   = 1'b0;
        IR    = 32'd0;

        tbl[0]  = '{"add",      32'h19890000, 1'b0, -1, 6, 0};
        tbl[1]  = '{"brnz_c0",  32'h93080019, 1'b0, -1, 7, 0};
        tbl[2]  = '{"brnz_c1",  32'h93080019, 1'b1, -1, 7, 0};
        tbl[3]  = '{"st",       32'h10000000, 1'b0, -1, 8, 0};
        tbl[4]  = '{"ld",       32'h00800000, 1'b0, -1, 8, 0};
        tbl[5]  = '{"ldi",      32'h08000000, 1'b0, -1, 6, 0};
        tbl[6]  = '{"neg",      32'h80000000, 1'b0, -1, 5, 0};
        tbl[7]  = '{"jal",      32'hA0000000, 1'b0, -1, 5, 0};
        tbl[8]  = '{"mfhi",     32'hB8000000, 1'b0, -1, 4, 0};
        tbl[9]  = '{"nop",      32'hC8000000, 1'b0, -1, 3, 0};
        tbl[10] = '{"undef",    32'hF8000000, 1'b0, -1, 3, 0};
        tbl[11] = '{"mul_stop", 32'h70000000, 1'b0,  4, 7, 1};
        tbl[12] = '{"halt",     32'hD0000000, 1'b0, -1, 3, 1};

        do_reset(2);

        for (int i = 0; i < 13; i++) begin
            run_instr(tbl[i].name, tbl[i].ir, tbl[i].con, tbl[i].stop_at, -1,
                      tbl[i].cycles, tbl[i].halt, h);
            if (h) after_halt();
        end

        // Reset landing on ld T6 must kill the rest of the load.
        run_instr("ld_abort", 32'h00000000, 1'b0, -1, 6, -1, -1, h);
        do_reset(2);

        // Stop raised during fetch is held until the instruction completes.
        run_instr("add_stop_fetch", 32'h19890000, 1'b0, 1, -1, -1, -1, h);
        if (h) after_halt();

        for (int i = 0; i < 80; i++) begin
            rop   = 5'($urandom_range(0, 31));
            rir   = {rop, 27'($urandom)};
            rstop = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
            run_instr($sformatf("rnd%0d_op%0d", i, rop), rir, 1'($urandom_range(0, 1)),
                      rstop, -1, -1, -1, h);
            if (h) after_halt();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
